// File: rtl/shift_add_multiplier_if.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_if
// Operand/result handshake bundle for the shift-add multiplier.
//   din_valid / din_ready     : operand handshake (producer -> multiplier)
//   multiplicand / multiplier : unsigned operands A and B, WIDTH bits each
//   dout_valid / dout_ready   : product handshake (multiplier -> consumer)
//   product                   : 2*WIDTH-bit unsigned result
//   busy                      : multiplier is computing or holding a result
// master = the side that supplies operands and consumes products,
// slave  = the multiplier itself.
// -----------------------------------------------------------------------------
interface shift_add_multiplier_if #(
   parameter int WIDTH = 4
);
   logic                 din_valid;
   logic                 din_ready;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output din_valid, multiplicand, multiplier, dout_ready,
      input  din_ready, dout_valid, product, busy
   );

   modport slave (
      input  din_valid, multiplicand, multiplier, dout_ready,
      output din_ready, dout_valid, product, busy
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned radix-2 shift-add multiplier, one partial product per
// clock. One multiplication in flight; WIDTH cycles from accept to result.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (returns to IDLE, clears product)
//   bus  : shift_add_multiplier_if.slave
//          din_valid/din_ready + multiplicand/multiplier in,
//          dout_valid/dout_ready + product out, busy status.
// din_ready, dout_valid and busy are decoded from the state register only.
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   shift_add_multiplier_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic [WIDTH-1:0]     a_reg;
   logic [2*WIDTH:0]     p_acc;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   product_reg;

   logic                 accept;
   logic                 last_step;
   logic [2*WIDTH:0]     p_step;

   // One radix-2 step: conditionally add A into the upper half (carry kept in
   // the extra top bit), then shift the whole accumulator right by one. The
   // multiplier bits drain out of the bottom as the product fills from the top.
   function automatic logic [2*WIDTH:0] shift_add_step(
      input logic [2*WIDTH:0] p,
      input logic [WIDTH-1:0] a
   );
      logic [WIDTH:0] sum;
      sum = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
      return {1'b0, sum, p[WIDTH-1:1]};
   endfunction

   assign p_step    = shift_add_step(p_acc, a_reg);
   assign accept    = (state == IDLE) && bus.din_valid;
   assign last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.din_valid)  state_nxt = CALC;
         CALC:    if (last_step)      state_nxt = DONE;
         DONE:    if (bus.dout_ready) state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // datapath: operands are captured only on the accept edge, so later
   // changes on the input bus cannot disturb a running computation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg       <= '0;
         p_acc       <= '0;
         cnt         <= '0;
         product_reg <= '0;
      end else if (accept) begin
         a_reg <= bus.multiplicand;
         p_acc <= {{(WIDTH+1){1'b0}}, bus.multiplier};
         cnt   <= '0;
      end else if (state == CALC) begin
         p_acc <= p_step;
         cnt   <= cnt + CW'(1);
         if (last_step) begin
            product_reg <= p_step[2*WIDTH-1:0];
         end
      end
   end

   assign bus.din_ready  = (state == IDLE);
   assign bus.dout_valid = (state == DONE);
   assign bus.busy       = (state != IDLE);
   assign bus.product    = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
// Bench for shift_add_multiplier at WIDTH=4 and WIDTH=8. Inputs are driven
// 1 time unit after the rising edge; everything is sampled on the falling edge.
// A scoreboard per instance holds A*B for every accepted operand pair and
// checks latency, product on each output handshake, and that dout_valid never
// appears without an outstanding operation.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift_add_multiplier_if #(.WIDTH(4)) if4 ();
   shift_add_multiplier_if #(.WIDTH(8)) if8 ();

   shift_add_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   shift_add_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- access helpers ----------------
   function automatic logic f_ready(input bit w8);
      return w8 ? if8.din_ready : if4.din_ready;
   endfunction
   function automatic logic f_valid(input bit w8);
      return w8 ? if8.dout_valid : if4.dout_valid;
   endfunction
   function automatic logic f_busy(input bit w8);
      return w8 ? if8.busy : if4.busy;
   endfunction
   function automatic logic [63:0] f_prod(input bit w8);
      return w8 ? 64'(if8.product) : 64'(if4.product);
   endfunction

   task automatic drive(input bit w8, input logic dv, input int a, input int b);
      if (w8) begin
         if8.din_valid    = dv;
         if8.multiplicand = 8'(a);
         if8.multiplier   = 8'(b);
      end else begin
         if4.din_valid    = dv;
         if4.multiplicand = 4'(a);
         if4.multiplier   = 4'(b);
      end
   endtask

   task automatic set_dr(input bit w8, input logic v);
      if (w8) if8.dout_ready = v;
      else    if4.dout_ready = v;
   endtask

   task automatic wait_ready(input bit w8, input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (f_ready(w8)) break;
      end
      chk(tag, 64'(f_ready(w8)), 64'd1);
   endtask

   task automatic wait_valid(input bit w8, input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (f_valid(w8)) break;
      end
      chk(tag, 64'(f_valid(w8)), 64'd1);
   endtask

   // ---------------- scoreboards ----------------
   logic [63:0] q4[$];
   logic [63:0] q8[$];
   bit          pend4, pend8;
   longint      acc4, acc8;

   always @(negedge clk) begin
      if (rst) begin
         q4.delete();
         pend4 = 1'b0;
      end else begin
         if (if4.din_valid && if4.din_ready) begin
            q4.push_back(64'(if4.multiplicand) * 64'(if4.multiplier));
            pend4 = 1'b1;
            acc4  = cyc;
         end
         if (if4.dout_valid && pend4) begin
            chk("w4_latency", 64'(cyc - acc4 - 1), 64'd4);
            pend4 = 1'b0;
         end
         if (q4.size() == 0)
            chk("w4_valid_without_op", 64'(if4.dout_valid), 64'd0);
         else if (if4.dout_valid && if4.dout_ready)
            chk("w4_product", 64'(if4.product), q4.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         pend8 = 1'b0;
      end else begin
         if (if8.din_valid && if8.din_ready) begin
            q8.push_back(64'(if8.multiplicand) * 64'(if8.multiplier));
            pend8 = 1'b1;
            acc8  = cyc;
         end
         if (if8.dout_valid && pend8) begin
            chk("w8_latency", 64'(cyc - acc8 - 1), 64'd8);
            pend8 = 1'b0;
         end
         if (q8.size() == 0)
            chk("w8_valid_without_op", 64'(if8.dout_valid), 64'd0);
         else if (if8.dout_valid && if8.dout_ready)
            chk("w8_product", 64'(if8.product), q8.pop_front());
      end
   end

   // ---------------- directed single operation ----------------
   // hold == 0: dout_ready tied high; otherwise held low for 'hold' DONE cycles.
   task automatic do_op(input bit w8, input int a, input int b, input int hold);
      logic [63:0] exp;
      exp = 64'(a) * 64'(b);
      @(posedge clk); #1;
      set_dr(w8, hold == 0);
      drive(w8, 1'b1, a, b);
      wait_ready(w8, "op_accept_timeout");
      @(posedge clk); #1;
      drive(w8, 1'b0, int'($urandom), int'($urandom));
      wait_valid(w8, "op_valid_timeout");
      chk("op_product", f_prod(w8), exp);
      chk("op_busy_done", 64'(f_busy(w8)), 64'd1);
      chk("op_ready_done", 64'(f_ready(w8)), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(f_valid(w8)), 64'd1);
         chk("hold_product", f_prod(w8), exp);
         chk("hold_ready", 64'(f_ready(w8)), 64'd0);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         set_dr(w8, 1'b1);
      end
      @(posedge clk); #1;
      set_dr(w8, 1'b0);
      @(negedge clk);
      chk("ret_ready", 64'(f_ready(w8)), 64'd1);
      chk("ret_valid", 64'(f_valid(w8)), 64'd0);
      chk("ret_busy", 64'(f_busy(w8)), 64'd0);
      chk("ret_product_kept", f_prod(w8), exp);
   endtask

   // ---------------- random sweep with backpressure ----------------
   task automatic sweep(input bit w8, input int n);
      bit done;
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < n; k++) begin
               @(posedge clk); #1;
               drive(w8, 1'b1, int'($urandom), int'($urandom));
               wait_ready(w8, "sweep_accept_timeout");
               @(posedge clk); #1;
               drive(w8, 1'b0, int'($urandom), int'($urandom));
               repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               set_dr(w8, $urandom_range(0, 3) != 0);
            end
         end
      join
      @(posedge clk); #1;
      set_dr(w8, 1'b1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((w8 ? q8.size() : q4.size()) == 0) break;
      end
      chk("sweep_drained", 64'(w8 ? q8.size() : q4.size()), 64'd0);
      @(posedge clk); #1;
      set_dr(w8, 1'b0);
   endtask

   longint acc_a, acc_b;

   initial begin
      drive(1'b0, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 0, 0);
      set_dr(1'b0, 1'b0);
      set_dr(1'b1, 1'b0);
      rst = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_ready", 64'(if4.din_ready), 64'd1);
      chk("rst_valid", 64'(if4.dout_valid), 64'd0);
      chk("rst_busy", 64'(if4.busy), 64'd0);
      chk("rst_product", 64'(if4.product), 64'd0);
      chk("rst_product_w8", 64'(if8.product), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // WIDTH=4 directed
      do_op(1'b0, 15, 15, 0);
      do_op(1'b0, 0, 13, 0);
      do_op(1'b0, 9, 0, 0);
      do_op(1'b0, 1, 11, 0);
      do_op(1'b0, 11, 1, 0);
      do_op(1'b0, 7, 6, 10);

      // back-to-back with din_valid held, operands changed after each accept
      @(posedge clk); #1;
      set_dr(1'b0, 1'b1);
      drive(1'b0, 1'b1, 3, 5);
      wait_ready(1'b0, "b2b_accept1_timeout");
      acc_a = cyc;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 12, 10);
      wait_valid(1'b0, "b2b_valid1_timeout");
      chk("b2b_first", 64'(if4.product), 64'd15);
      wait_ready(1'b0, "b2b_accept2_timeout");
      acc_b = cyc;
      chk("b2b_interval", 64'(acc_b - acc_a), 64'd6);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1, 1);
      wait_valid(1'b0, "b2b_valid2_timeout");
      chk("b2b_second", 64'(if4.product), 64'd120);
      @(posedge clk); #1;
      set_dr(1'b0, 1'b0);

      // reset during CALC
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 13, 14);
      wait_ready(1'b0, "abort_accept_timeout");
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 0, 0);
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("abort_product", 64'(if4.product), 64'd0);
      chk("abort_valid", 64'(if4.dout_valid), 64'd0);
      chk("abort_busy", 64'(if4.busy), 64'd0);
      chk("abort_ready", 64'(if4.din_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      set_dr(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("abort_no_report", 64'(if4.dout_valid), 64'd0);
      end
      do_op(1'b0, 2, 3, 0);

      // WIDTH=8
      do_op(1'b1, 255, 255, 0);
      sweep(1'b1, 1000);
      sweep(1'b0, 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #900000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
